ccff_chain_loader: RTL and testbench

- Configuration-chain sequencer for the CLB logic-element fabric.
- Accepts bitstream words on a valid/ready stream and serialises exactly CHAIN_LEN bits onto a configuration flip-flop chain (ccff_head in, ccff_tail out), gating shifting with ccff_shift_en.
- Counts the ones emerging at ccff_tail so software can verify the previous configuration by reloading.
- Sits between the bitstream DMA/JTAG bridge and the tile's chain head, in the prog_clk domain.

---
 rtl/ccff_cfg_pkg.sv | 34 +++
 rtl/ccff_word_serializer.sv | 106 ++++++++++
 rtl/ccff_chain_loader.sv | 140 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_cfg_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_cfg_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Number of input words needed to cover the whole chain.
    function automatic int words_needed(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits actually shifted from the final word; the low pad bits are dropped.
    function automatic int last_word_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

    // Width of a counter that must hold 0..n inclusive.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Sizing for the default fabric tile (40-bit chain, byte-wide bitstream).
    localparam int DEF_CHAIN_LEN    = 40;
    localparam int DEF_WORD_W       = 8;
    localparam int DEF_COUNT_W      = count_width(DEF_CHAIN_LEN);
    localparam int DEF_WORDS_NEEDED = words_needed(DEF_CHAIN_LEN, DEF_WORD_W);
    localparam int DEF_LAST_BITS    = last_word_bits(DEF_CHAIN_LEN, DEF_WORD_W);

endpackage

// File: rtl/ccff_word_serializer.sv
// One-word buffer that turns accepted bitstream words into an MSB-first
// serial stream with a registered head bit and shift enable.
module ccff_word_serializer
    import ccff_cfg_pkg::*;
#(
    parameter int WORD_W       = 8,
    parameter int WORDS_NEEDED = 5,
    parameter int LAST_BITS    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              clear,
    input  logic              enable,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              accept,
    output logic              waiting,
    output logic              shift_en,
    output logic              head
);

    localparam int REM_W = count_width(WORD_W);
    localparam int WL_W  = count_width(WORDS_NEEDED);
    // rem counts bits still in the buffer behind the bit currently on head.
    localparam logic [REM_W-1:0] REM_FULL  = REM_W'(WORD_W - 1);
    localparam logic [REM_W-1:0] REM_LAST  = REM_W'(LAST_BITS - 1);
    localparam logic [WL_W-1:0]  WL_START  = WL_W'(WORDS_NEEDED);

    logic [WORD_W-1:0] buf_reg, buf_next;
    logic [REM_W-1:0]  rem_reg, rem_next;
    logic [WL_W-1:0]   words_left_reg, words_left_next;
    logic              shift_en_reg, shift_en_next;
    logic              head_reg, head_next;
    logic [WORD_W-1:0] buf_shl;
    logic [WORD_W-1:0] data_shl;

    // Left-shift by one of both the buffer and the incoming word.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign buf_shl[gi]  = 1'b0;
                assign data_shl[gi] = 1'b0;
            end else begin : g_upper
                assign buf_shl[gi]  = buf_reg[gi-1];
                assign data_shl[gi] = cfg_data[gi-1];
            end
        end
    endgenerate

    // Ready as soon as the buffer is empty, so the next word's MSB follows
    // the current word's LSB with no gap.
    assign cfg_ready = enable && (rem_reg == '0) && (words_left_reg != '0);
    assign accept    = cfg_valid && cfg_ready;
    assign waiting   = (rem_reg == '0) && (words_left_reg != '0) && !shift_en_reg;
    assign shift_en  = shift_en_reg;
    assign head      = head_reg;

    // Next-state: load a word onto head, or shift the next buffered bit out.
    always_comb begin
        buf_next        = buf_reg;
        rem_next        = rem_reg;
        words_left_next = words_left_reg;
        shift_en_next   = 1'b0;
        head_next       = head_reg;
        if (clear) begin
            buf_next        = '0;
            rem_next        = '0;
            words_left_next = WL_START;
            head_next       = 1'b0;
        end else if (!enable) begin
            buf_next = '0;
            rem_next = '0;
        end else if (accept) begin
            head_next       = cfg_data[WORD_W-1];
            shift_en_next   = 1'b1;
            buf_next        = data_shl;
            rem_next        = (words_left_reg == WL_W'(1)) ? REM_LAST : REM_FULL;
            words_left_next = words_left_reg - WL_W'(1);
        end else if (rem_reg != '0) begin
            head_next     = buf_reg[WORD_W-1];
            shift_en_next = 1'b1;
            buf_next      = buf_shl;
            rem_next      = rem_reg - REM_W'(1);
        end
    end

    // Buffer, counters and registered chain outputs.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            buf_reg        <= '0;
            rem_reg        <= '0;
            words_left_reg <= '0;
            shift_en_reg   <= 1'b0;
            head_reg       <= 1'b0;
        end else begin
            buf_reg        <= buf_next;
            rem_reg        <= rem_next;
            words_left_reg <= words_left_next;
            shift_en_reg   <= shift_en_next;
            head_reg       <= head_next;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain sequencer: serialises exactly CHAIN_LEN bitstream bits
// onto the config flip-flop chain and counts ones returning at the tail.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic                           prog_clk,
    input  logic                           pReset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [WORD_W-1:0]              cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic                           ccff_head,
    output logic                           ccff_shift_en,
    input  logic                           ccff_tail,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bits_loaded,
    output logic [$clog2(CHAIN_LEN+1)-1:0] tail_ones
);
    import ccff_cfg_pkg::*;

    localparam int CNT_W        = $clog2(CHAIN_LEN + 1);
    localparam int STALL_W      = count_width(TIMEOUT);
    localparam int WORDS_NEEDED = words_needed(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS    = last_word_bits(CHAIN_LEN, WORD_W);
    localparam logic [CNT_W-1:0]   FINAL_BIT   = CNT_W'(CHAIN_LEN - 1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT - 1);

    state_e             state_reg, state_next;
    logic [CNT_W-1:0]   bits_reg, bits_next;
    logic [CNT_W-1:0]   ones_reg, ones_next;
    logic [STALL_W-1:0] stall_reg, stall_next;

    logic load_entry;
    logic in_load;
    logic ser_enable;
    logic ser_accept;
    logic ser_waiting;
    logic ser_shift_en;
    logic ser_head;
    logic starved;

    assign in_load    = (state_reg == ST_LOAD);
    assign load_entry = start && !in_load;
    // Abort removes the enable in its own cycle so no further bit is issued.
    assign ser_enable = in_load && !abort;
    assign starved    = in_load && ser_waiting && !ser_accept;

    ccff_word_serializer #(
        .WORD_W       (WORD_W),
        .WORDS_NEEDED (WORDS_NEEDED),
        .LAST_BITS    (LAST_BITS)
    ) u_serializer (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .clear     (load_entry),
        .enable    (ser_enable),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .accept    (ser_accept),
        .waiting   (ser_waiting),
        .shift_en  (ser_shift_en),
        .head      (ser_head)
    );

    // Next-state logic: abort beats completion, completion beats timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_ERR;
                end else if (ser_shift_en && (bits_reg == FINAL_BIT)) begin
                    state_next = ST_DONE;
                end else if (starved && (stall_reg == STALL_LIMIT)) begin
                    state_next = ST_ERR;
                end
            end
            default: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
        endcase
    end

    // Shift/tail counters and starvation timer; frozen outside LOAD.
    always_comb begin
        bits_next  = bits_reg;
        ones_next  = ones_reg;
        stall_next = stall_reg;
        if (load_entry) begin
            bits_next  = '0;
            ones_next  = '0;
            stall_next = '0;
        end else if (in_load) begin
            if (ser_shift_en) begin
                bits_next = bits_reg + CNT_W'(1);
                if (ccff_tail) begin
                    ones_next = ones_reg + CNT_W'(1);
                end
            end
            if (ser_accept) begin
                stall_next = '0;
            end else if (starved) begin
                stall_next = stall_reg + STALL_W'(1);
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_reg <= ST_IDLE;
            bits_reg  <= '0;
            ones_reg  <= '0;
            stall_reg <= '0;
        end else begin
            state_reg <= state_next;
            bits_reg  <= bits_next;
            ones_reg  <= ones_next;
            stall_reg <= stall_next;
        end
    end

    // Head is held between shifts during a load and parked at 0 otherwise.
    assign ccff_shift_en = in_load && ser_shift_en;
    assign ccff_head     = in_load && ser_head;
    assign busy          = in_load;
    assign done          = (state_reg == ST_DONE);
    assign error         = (state_reg == ST_ERR);
    assign bits_loaded   = bits_reg;
    assign tail_ones     = ones_reg;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for the chain loader: a 40-bit/byte instance and a
// 10-bit/TIMEOUT=16 instance, each feeding a behavioural shift-register chain.
module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic pReset;

    // Instance A: CHAIN_LEN=40, WORD_W=8, TIMEOUT=255
    logic       a_start, a_abort, a_valid, a_ready, a_head, a_shift_en, a_tail;
    logic       a_busy, a_done, a_error;
    logic [7:0] a_data;
    logic [5:0] a_bits, a_ones;

    // Instance B: CHAIN_LEN=10, WORD_W=8, TIMEOUT=16
    logic       b_start, b_abort, b_valid, b_ready, b_head, b_shift_en, b_tail;
    logic       b_busy, b_done, b_error;
    logic [7:0] b_data;
    logic [3:0] b_bits, b_ones;

    ccff_chain_loader #(.CHAIN_LEN(40), .WORD_W(8), .TIMEOUT(255)) dut_a (
        .prog_clk(prog_clk), .pReset(pReset), .start(a_start), .abort(a_abort),
        .cfg_data(a_data), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .ccff_head(a_head), .ccff_shift_en(a_shift_en), .ccff_tail(a_tail),
        .busy(a_busy), .done(a_done), .error(a_error),
        .bits_loaded(a_bits), .tail_ones(a_ones)
    );

    ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(8), .TIMEOUT(16)) dut_b (
        .prog_clk(prog_clk), .pReset(pReset), .start(b_start), .abort(b_abort),
        .cfg_data(b_data), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .ccff_head(b_head), .ccff_shift_en(b_shift_en), .ccff_tail(b_tail),
        .busy(b_busy), .done(b_done), .error(b_error),
        .bits_loaded(b_bits), .tail_ones(b_ones)
    );

    // Behavioural configuration chains: first bit in ends up at the tail.
    logic [39:0] chain_a;
    logic [9:0]  chain_b;
    assign a_tail = chain_a[39];
    assign b_tail = chain_b[9];
    always @(posedge prog_clk) begin
        if (a_shift_en) chain_a <= {chain_a[38:0], a_head};
        if (b_shift_en) chain_b <= {chain_b[8:0], b_head};
    end

    int vectors = 0;
    int miscompares = 0;

    logic sel;
    logic m_shift, m_head, m_ready, m_done, m_error;
    assign m_shift = sel ? b_shift_en : a_shift_en;
    assign m_head  = sel ? b_head     : a_head;
    assign m_ready = sel ? b_ready    : a_ready;
    assign m_done  = sel ? b_done     : a_done;
    assign m_error = sel ? b_error    : a_error;

    task automatic drive(input logic s, input logic v, input logic [7:0] d,
                         input logic st, input logic ab);
        if (s) begin
            b_valid = v; b_data = d; b_start = st; b_abort = ab;
        end else begin
            a_valid = v; a_data = d; a_start = st; a_abort = ab;
        end
    endtask

    // Start a load and stream words from pat (MSB byte first), with an optional
    // ready-qualified valid gap before word gap_before and an optional stop
    // event (1 abort, 2 pReset, 3 start+abort) once stop_at shifts are seen.
    task automatic run_load(input logic s, input logic [39:0] pat, input int nwords,
                            input int gap_before, input int gap_len,
                            input int stop_at, input int stop_kind,
                            output int shifts, output logic [39:0] hbits,
                            output int first, output int last,
                            output int done_cyc, output int err_cyc,
                            output bit late_ready, output int ent_bits);
        int  idx = 0;
        int  gap_cnt = 0;
        int  ended = 0;
        bit  stopped = 0;
        logic v, st, ab;
        logic [7:0] d;
        sel = s;
        shifts = 0; hbits = '0; first = -1; last = -1;
        done_cyc = -1; err_cyc = -1; late_ready = 0; ent_bits = -1;
        @(posedge prog_clk); #1;
        drive(s, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge prog_clk); #1;
            v = 1'b0; d = 8'h00; st = 1'b0; ab = 1'b0;
            if (cyc == 0) ent_bits = s ? int'(b_bits) : int'(a_bits);
            if (m_shift) begin
                shifts++;
                hbits = {hbits[38:0], m_head};
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (m_done  && done_cyc < 0) done_cyc = cyc;
            if (m_error && err_cyc  < 0) err_cyc  = cyc;
            if (done_cyc >= 0 || err_cyc >= 0) begin
                ended++;
                if (ended > 4) break;
            end
            if (idx == nwords && m_ready) late_ready = 1;
            if (stop_kind != 0 && !stopped && m_shift && shifts == stop_at) begin
                stopped = 1;
                if (stop_kind == 2) begin
                    drive(s, 1'b0, 8'h00, 1'b0, 1'b0);
                    pReset = 1'b1;
                    break;
                end
                ab = 1'b1;
                st = (stop_kind == 3);
            end
            if (idx < nwords) begin
                if (idx == gap_before && gap_cnt < gap_len) begin
                    if (m_ready) gap_cnt++;
                end else begin
                    v = 1'b1;
                    d = pat[39-8*idx -: 8];
                    if (m_ready) idx++;
                end
            end
            drive(s, v, d, st, ab);
        end
        if (stop_kind != 2) drive(s, 1'b0, 8'h00, 1'b0, 1'b0);
        $display("load %s: shifts=%0d first=%0d last=%0d done@%0d err@%0d",
                 s ? "B" : "A", shifts, first, last, done_cyc, err_cyc);
    endtask

    int          sh, fi, la, dc, ec, eb;
    logic [39:0] hb;
    bit          lr;
    logic [39:0] pre;
    int          exp_ones;

    localparam logic [39:0] PAT_P = 40'hA5_3C_FF_00_81;
    localparam logic [39:0] PAT_Q = 40'h0F_1E_2D_3C_4B;
    localparam logic [39:0] PAT_R = 40'h12_34_56_78_9A;

    task automatic test_reset();
        pReset = 1'b1;
        repeat (3) @(posedge prog_clk);
        #1;
        vectors++;
        if ({a_busy, a_done, a_error, a_ready, a_shift_en, a_head, a_bits, a_ones} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_a: outputs=%h expected 0",
                     {a_busy, a_done, a_error, a_ready, a_shift_en, a_head, a_bits, a_ones});
        end
        pReset = 1'b0;
        @(posedge prog_clk); #1;
        vectors++;
        if ({b_busy, b_done, b_error, b_ready, b_shift_en, b_head, b_bits, b_ones} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_b_idle: outputs=%h expected 0",
                     {b_busy, b_done, b_error, b_ready, b_shift_en, b_head, b_bits, b_ones});
        end
    endtask

    task automatic test_stream();
        exp_ones = $countones(chain_a);
        run_load(1'b0, PAT_P, 5, -1, 0, 0, 0, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (sh !== 40) begin miscompares++; $display("FAIL stream_shifts: got %0d expected 40", sh); end
        vectors++; if (hb !== PAT_P) begin miscompares++; $display("FAIL stream_head: got %h expected %h", hb, PAT_P); end
        vectors++; if (fi !== 1) begin miscompares++; $display("FAIL stream_latency: first shift cycle %0d expected 1", fi); end
        vectors++; if (la - fi + 1 !== 40) begin miscompares++; $display("FAIL stream_gapless: span %0d expected 40", la - fi + 1); end
        vectors++; if (dc !== la + 1) begin miscompares++; $display("FAIL stream_done: done cycle %0d expected %0d", dc, la + 1); end
        vectors++; if (a_bits !== 6'd40) begin miscompares++; $display("FAIL stream_bits: got %0d expected 40", a_bits); end
        vectors++; if (int'(a_ones) !== exp_ones) begin miscompares++; $display("FAIL stream_tail: got %0d expected %0d", a_ones, exp_ones); end
        vectors++; if ({a_done, a_busy, a_error} !== 3'b100) begin miscompares++; $display("FAIL stream_state: done/busy/error=%b expected 100", {a_done, a_busy, a_error}); end
    endtask

    task automatic test_reload();
        run_load(1'b0, PAT_Q, 5, -1, 0, 0, 0, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (chain_a !== PAT_Q) begin miscompares++; $display("FAIL reload_chain: got %h expected %h", chain_a, PAT_Q); end
        vectors++; if (a_ones !== 6'd18) begin miscompares++; $display("FAIL reload_tail_ones: got %0d expected 18", a_ones); end
        vectors++; if (a_bits !== 6'd40) begin miscompares++; $display("FAIL reload_bits: got %0d expected 40", a_bits); end
    endtask

    task automatic test_gap();
        run_load(1'b0, PAT_R, 5, 2, 20, 0, 0, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (sh !== 40) begin miscompares++; $display("FAIL gap_shifts: got %0d expected 40", sh); end
        vectors++; if (la - fi + 1 !== 60) begin miscompares++; $display("FAIL gap_span: got %0d expected 60", la - fi + 1); end
        vectors++; if (hb !== PAT_R) begin miscompares++; $display("FAIL gap_head: got %h expected %h", hb, PAT_R); end
        vectors++; if (chain_a !== PAT_R) begin miscompares++; $display("FAIL gap_chain: got %h expected %h", chain_a, PAT_R); end
        vectors++; if (a_ones !== 6'd20) begin miscompares++; $display("FAIL gap_tail_ones: got %0d expected 20", a_ones); end
        vectors++; if ({a_done, a_error} !== 2'b10 || dc !== la + 1) begin miscompares++; $display("FAIL gap_done: done/error=%b done cycle %0d expected 10 at %0d", {a_done, a_error}, dc, la + 1); end
    endtask

    task automatic test_short_chain();
        run_load(1'b1, 40'hFF_C0_00_00_00, 2, -1, 0, 0, 0, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (sh !== 10) begin miscompares++; $display("FAIL short_shifts: got %0d expected 10", sh); end
        vectors++; if (hb[9:0] !== 10'h3FF) begin miscompares++; $display("FAIL short_head: got %h expected 3ff", hb[9:0]); end
        vectors++; if (lr !== 1'b0) begin miscompares++; $display("FAIL short_ready_after_last: got %0d expected 0", lr); end
        vectors++; if (chain_b !== 10'h3FF) begin miscompares++; $display("FAIL short_chain: got %h expected 3ff", chain_b); end
        vectors++; if (b_bits !== 4'd10 || dc !== la + 1) begin miscompares++; $display("FAIL short_done: bits %0d done cycle %0d expected 10 at %0d", b_bits, dc, la + 1); end
    endtask

    task automatic test_timeout();
        run_load(1'b1, 40'h5A_C3_00_00_00, 2, 1, 100, 0, 0, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (sh !== 8) begin miscompares++; $display("FAIL timeout_shifts: got %0d expected 8", sh); end
        vectors++; if (ec !== la + 17) begin miscompares++; $display("FAIL timeout_cycle: error at %0d expected %0d", ec, la + 17); end
        vectors++; if ({b_busy, b_error, b_done} !== 3'b010) begin miscompares++; $display("FAIL timeout_state: busy/error/done=%b expected 010", {b_busy, b_error, b_done}); end
        vectors++; if (b_bits !== 4'd8) begin miscompares++; $display("FAIL timeout_bits: got %0d expected 8", b_bits); end
    endtask

    task automatic test_abort();
        pre = chain_a;
        exp_ones = $countones(pre[39:27]);
        run_load(1'b0, PAT_P, 5, -1, 0, 13, 1, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (ec !== la + 1) begin miscompares++; $display("FAIL abort_latency: error at %0d expected %0d", ec, la + 1); end
        vectors++; if (sh !== 13) begin miscompares++; $display("FAIL abort_no_more_shifts: got %0d expected 13", sh); end
        vectors++; if (a_bits !== 6'd13) begin miscompares++; $display("FAIL abort_bits_frozen: got %0d expected 13", a_bits); end
        vectors++; if (int'(a_ones) !== exp_ones) begin miscompares++; $display("FAIL abort_tail_frozen: got %0d expected %0d", a_ones, exp_ones); end
        vectors++; if ({a_busy, a_error, a_ready} !== 3'b010) begin miscompares++; $display("FAIL abort_state: busy/error/ready=%b expected 010", {a_busy, a_error, a_ready}); end
        exp_ones = $countones(chain_a);
        run_load(1'b0, PAT_P, 5, -1, 0, 0, 0, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (eb !== 0) begin miscompares++; $display("FAIL restart_clear: bits at entry %0d expected 0", eb); end
        vectors++; if (sh !== 40 || a_bits !== 6'd40 || a_done !== 1'b1) begin miscompares++; $display("FAIL restart_full: shifts %0d bits %0d done %0d expected 40/40/1", sh, a_bits, a_done); end
        vectors++; if (int'(a_ones) !== exp_ones || chain_a !== PAT_P) begin miscompares++; $display("FAIL restart_chain: ones %0d chain %h expected %0d %h", a_ones, chain_a, exp_ones, PAT_P); end
    endtask

    task automatic test_start_abort();
        run_load(1'b0, PAT_Q, 5, -1, 0, 5, 3, sh, hb, fi, la, dc, ec, lr, eb);
        vectors++; if (ec !== la + 1 || a_error !== 1'b1 || a_busy !== 1'b0) begin miscompares++; $display("FAIL start_abort: error at %0d err=%0d busy=%0d expected at %0d 1 0", ec, a_error, a_busy, la + 1); end
        vectors++; if (a_bits !== 6'd5 || sh !== 5) begin miscompares++; $display("FAIL start_abort_bits: got %0d shifts %0d expected 5", a_bits, sh); end
    endtask

    task automatic test_reset_mid();
        run_load(1'b0, PAT_R, 5, -1, 0, 20, 2, sh, hb, fi, la, dc, ec, lr, eb);
        #1;
        vectors++;
        if ({a_busy, a_done, a_error, a_ready, a_shift_en, a_head, a_bits, a_ones} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_mid_async: outputs=%h expected 0",
                     {a_busy, a_done, a_error, a_ready, a_shift_en, a_head, a_bits, a_ones});
        end
        @(negedge prog_clk);
        pReset = 1'b0;
        @(posedge prog_clk); #1;
        a_abort = 1'b1;
        @(posedge prog_clk); #1;
        a_abort = 1'b0;
        @(posedge prog_clk); #1;
        vectors++;
        if ({a_busy, a_done, a_error, a_shift_en, a_bits} !== 10'd0) begin
            miscompares++;
            $display("FAIL abort_in_idle: busy/done/error/shift/bits=%h expected 0",
                     {a_busy, a_done, a_error, a_shift_en, a_bits});
        end
    endtask

    initial begin
        chain_a = '0;
        chain_b = '0;
        sel = 1'b0;
        pReset = 1'b1;
        a_start = 0; a_abort = 0; a_valid = 0; a_data = 0;
        b_start = 0; b_abort = 0; b_valid = 0; b_data = 0;
        test_reset();
        test_stream();
        test_reload();
        test_gap();
        test_short_chain();
        test_timeout();
        test_abort();
        test_start_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
